// File: rtl/fetch_controller.sv
// Multicycle instruction-fetch sequencer. It owns the PC load path, runs the
// single-outstanding request/ack handshake with instruction memory, hands each
// fetched word to decode and resolves the next PC once execute finishes.
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_value,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        stall,
  input  logic        exec_done,
  input  logic        exec_redirect,
  input  logic [31:0] exec_target,
  input  logic        trap_req,
  output logic        trap_taken
);

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    ISSUE,
    EXECUTE,
    UPDATE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        req_pending;   // request raised and not yet acknowledged
  logic [31:0] instr_q;       // word held for decode
  logic [31:0] target_q;      // resolved next PC, presented during UPDATE
  logic        trap_q;        // the resolved next PC is a trap-vector load

  logic        req_c;
  logic        load_c;
  logic        valid_c;
  logic        trap_c;
  logic [31:0] next_c;

  logic [31:0] resolve_pc;
  logic        resolve_trap;

  // Next-PC resolution for the instruction that is finishing execute.
  always_comb begin
    resolve_pc   = pc_value + 32'd4;
    resolve_trap = 1'b0;
    if (trap_req) begin
      resolve_pc   = TRAP_VECTOR;
      resolve_trap = 1'b1;
    end else if (exec_redirect && (exec_target[1:0] != 2'b00)) begin
      resolve_pc   = TRAP_VECTOR;
      resolve_trap = 1'b1;
    end else if (exec_redirect) begin
      resolve_pc   = exec_target;
    end
  end

  // Next-state and raw (pre-reset-gating) output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in combinational logic is a latch.
    state_nxt = state;
    req_c     = 1'b0;
    load_c    = 1'b0;
    valid_c   = 1'b0;
    trap_c    = 1'b0;
    next_c    = '0;
    case (state)
      BOOT: begin
        load_c    = 1'b1;
        next_c    = RESET_VECTOR;
        state_nxt = FETCH;
      end
      FETCH: begin
        // Once raised, the request is held through stall until acknowledged.
        req_c = req_pending || !stall;
        if (req_c && imem_ack) state_nxt = ISSUE;
      end
      ISSUE: begin
        valid_c = 1'b1;
        if (instr_ready) state_nxt = EXECUTE;
      end
      EXECUTE: begin
        if (exec_done) state_nxt = UPDATE;
      end
      UPDATE: begin
        load_c    = 1'b1;
        next_c    = target_q;
        trap_c    = trap_q;
        state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state       <= BOOT;
      req_pending <= 1'b0;
      instr_q     <= '0;
      target_q    <= '0;
      trap_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_pending <= req_c && !imem_ack;
      if (req_c && imem_ack) instr_q <= imem_rdata;
      if (state == EXECUTE && exec_done) begin
        target_q <= resolve_pc;
        trap_q   <= resolve_trap;
      end
    end
  end

  // While reset is asserted every output reads 0, whatever the current state.
  assign pc_load     = reset & load_c;
  assign pc_next     = reset ? next_c : '0;
  assign imem_req    = reset & req_c;
  assign imem_addr   = imem_req ? pc_value : '0;
  assign instr       = reset ? instr_q : '0;
  assign instr_valid = reset & valid_c;
  assign trap_taken  = reset & trap_c;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller. A driver applies random handshake and
// execute inputs (plus reset pulses); a negedge monitor tracks the instruction
// life cycle at transaction level and compares against scoreboard queues.
module tb_fetch_controller;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
  localparam int          RUN_CYCLES   = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_value;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        exec_done;
  logic        exec_redirect;
  logic [31:0] exec_target;
  logic        trap_req;
  logic        trap_taken;

  fetch_controller #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_value     (pc_value),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .stall        (stall),
    .exec_done    (exec_done),
    .exec_redirect(exec_redirect),
    .exec_target  (exec_target),
    .trap_req     (trap_req),
    .trap_taken   (trap_taken)
  );

  always #5 clk = ~clk;

  // The PC register the controller drives (not reset; BOOT initialises it).
  logic [31:0] pc_reg = 32'hDEAD_BEE0;
  always @(posedge clk) if (pc_load) pc_reg <= pc_next;
  assign pc_value = pc_reg;

  int n_vec  = 0;
  int n_err  = 0;
  int n_load = 0;
  int n_trap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic        trap;
    int          due;
  } load_t;

  load_t       load_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] model_pc     = '0;
  logic [31:0] req_addr     = '0;
  logic        boot_pending = 1'b0;
  logic        fetch_phase  = 1'b0;
  logic        issue_phase  = 1'b0;
  logic        exec_phase   = 1'b0;
  logic        req_wait     = 1'b0;
  int          cyc          = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rst_pc_load", {31'b0, pc_load}, 32'd0);
      check("rst_pc_next", pc_next, 32'd0);
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_trap_taken", {31'b0, trap_taken}, 32'd0);
      load_q.delete();
      instr_q.delete();
      fetch_phase  = 1'b0;
      issue_phase  = 1'b0;
      exec_phase   = 1'b0;
      req_wait     = 1'b0;
      boot_pending = 1'b1;
    end else begin
      if (boot_pending) begin
        load_q.push_back('{pc: RESET_VECTOR, trap: 1'b0, due: cyc});
        boot_pending = 1'b0;
      end

      // Execute finishing: the next PC follows trap > misaligned > redirect > +4.
      if (exec_phase && exec_done) begin
        load_t e;
        e.due = cyc + 1;
        if (trap_req) begin
          e.pc = TRAP_VECTOR; e.trap = 1'b1;
        end else if (exec_redirect && (exec_target % 4 != 0)) begin
          e.pc = TRAP_VECTOR; e.trap = 1'b1;
        end else if (exec_redirect) begin
          e.pc = exec_target; e.trap = 1'b0;
        end else begin
          e.pc = model_pc + 32'd4; e.trap = 1'b0;
        end
        load_q.push_back(e);
        exec_phase = 1'b0;
      end

      // Decode hand-off.
      if (issue_phase) begin
        check("instr_valid_held", {31'b0, instr_valid}, 32'd1);
        check("instr_value", instr, instr_q[0]);
        if (instr_ready) begin
          void'(instr_q.pop_front());
          issue_phase = 1'b0;
          exec_phase  = 1'b1;
        end
      end else begin
        check("instr_valid_idle", {31'b0, instr_valid}, 32'd0);
      end

      // Memory request: raised unless stalled, held until acked.
      if (fetch_phase) begin
        check("imem_req", {31'b0, imem_req}, {31'b0, req_wait || !stall});
        if (imem_req) begin
          check("imem_addr", imem_addr, model_pc);
          if (req_wait) check("imem_addr_stable", imem_addr, req_addr);
          req_addr = imem_addr;
          if (imem_ack) begin
            instr_q.push_back(imem_rdata);
            fetch_phase = 1'b0;
            issue_phase = 1'b1;
          end
        end
        req_wait = imem_req && !imem_ack;
      end else begin
        check("imem_req_idle", {31'b0, imem_req}, 32'd0);
        req_wait = 1'b0;
      end
      if (!imem_req) check("imem_addr_idle", imem_addr, 32'd0);

      // PC load strobe, exactly in the cycle the model scheduled it.
      if (load_q.size() > 0 && load_q[0].due == cyc) begin
        load_t e;
        e = load_q.pop_front();
        check("pc_load", {31'b0, pc_load}, 32'd1);
        check("pc_next", pc_next, e.pc);
        check("trap_taken", {31'b0, trap_taken}, {31'b0, e.trap});
        model_pc    = e.pc;
        fetch_phase = 1'b1;
        n_load++;
        if (e.trap) n_trap++;
      end else begin
        check("no_spurious_load", {30'b0, pc_load, trap_taken}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_random();
    logic [31:0] t;
    stall         = ($urandom_range(0, 3) == 0);
    imem_ack      = ($urandom_range(0, 1) == 1);
    imem_rdata    = $urandom;
    instr_ready   = ($urandom_range(0, 4) < 3);
    exec_done     = ($urandom_range(0, 4) < 2);
    exec_redirect = ($urandom_range(0, 1) == 1);
    trap_req      = ($urandom_range(0, 6) == 0);
    t = $urandom;
    case ($urandom_range(0, 4))
      0:       exec_target = 32'd47;
      1:       exec_target = 32'd48;
      2:       exec_target = 32'hFFFF_FFFC;
      3:       exec_target = {t[31:2], 2'b00};
      default: exec_target = t;
    endcase
  endtask

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    instr_ready   = 1'b0;
    exec_done     = 1'b0;
    exec_redirect = 1'b0;
    exec_target   = '0;
    trap_req      = 1'b0;

    for (int c = 0; c < RUN_CYCLES; c++) begin
      @(posedge clk);
      #1;
      if (c == RUN_CYCLES / 2) begin
        // Reset in the middle of a memory handshake, with an ack arriving
        // during reset that must be dropped.
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          stall = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
          exec_done = 1'b1; exec_redirect = 1'b0; trap_req = 1'b0;
          #1;
          if (imem_req) seen = 1'b1;
          else begin
            @(posedge clk);
            #1;
          end
        end
        check("midreset_req_seen", {31'b0, seen}, 32'd1);
        reset    = 1'b0;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_random();
      end else begin
        drive_random();
        if (c < 2) reset = 1'b0;
        else       reset = ($urandom_range(0, 499) != 0);
      end
    end

    @(negedge clk);
    check("instructions_completed", {31'b0, n_load >= 100}, 32'd1);
    check("traps_seen", {31'b0, n_trap > 0}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
